// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory-stage responder: op codes, FSM states,
// default geometry and the request-bit decoder.
package mem_resp_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        OP_READ,
        OP_WRITE,
        OP_PUSH,
        OP_POP,
        OP_ILLEGAL
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    // Anything other than exactly one op bit is an illegal request.
    function automatic op_e decode_op(input logic rd, input logic wr,
                                      input logic pu, input logic po);
        case ({rd, wr, pu, po})
            4'b1000: return OP_READ;
            4'b0100: return OP_WRITE;
            4'b0010: return OP_PUSH;
            4'b0001: return OP_POP;
            default: return OP_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Memory-stage request/response bundle between the processor (master)
// and the data memory responder (slave).
interface data_mem_responder_if
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic              memory_read;
    logic              memory_write;
    logic              memory_push;
    logic              memory_pop;
    logic [15:0]       address;
    logic [DATA_W-1:0] write_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] sp;
    logic              err_overflow;
    logic              err_underflow;
    logic              err_illegal;

    modport master (
        output req_valid, memory_read, memory_write, memory_push, memory_pop,
               address, write_data,
        input  req_ready, rsp_valid, rsp_data, sp,
               err_overflow, err_underflow, err_illegal
    );

    modport slave (
        input  req_valid, memory_read, memory_write, memory_push, memory_pop,
               address, write_data,
        output req_ready, rsp_valid, rsp_data, sp,
               err_overflow, err_underflow, err_illegal
    );

endinterface

// File: rtl/data_mem_responder_sp_ram.sv
// Single-port synchronous RAM, 2^ADDR_W x DATA_W, write-enable and read-enable.
// Latency: read data registered one cycle after a read-enabled edge.
// Backpressure: none; output register holds until the next read-enabled edge.
module sp_ram #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage responder: read/write/push/pop against a data RAM, owns the stack pointer.
// Latency: response strobe WAIT_STATES+1 cycles after the accept edge, one cycle wide.
// Backpressure: req_ready only in IDLE; one request per WAIT_STATES+2 cycles.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int              ADDR_W      = ADDR_W_DEF,
    parameter int              DATA_W      = DATA_W_DEF,
    parameter int              WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] SP_TOP    = {ADDR_W{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mem_responder_if.slave   bus
);

    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    state_e            state, state_nxt;
    req_t              req_in, req_q, req_cur;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] sp_q;
    logic              accept, commit, wait_done;
    logic              stack_full, stack_empty;
    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic              rsp_from_ram;
    logic              err_ov_q, err_un_q, err_il_q;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^bus.address;

    assign req_in = '{op:   decode_op(bus.memory_read, bus.memory_write,
                                      bus.memory_push, bus.memory_pop),
                      addr: bus.address[ADDR_W-1:0],
                      data: bus.write_data};

    // With zero wait states the op commits on the accept edge itself,
    // before the capture register has been loaded.
    assign req_cur     = (state == S_IDLE) ? req_in : req_q;
    assign accept      = bus.req_valid && (state == S_IDLE);
    assign wait_done   = (WAIT_STATES == 0) || (int'(wait_cnt) == WAIT_STATES - 1);
    assign stack_full  = (sp_q == '0);
    assign stack_empty = (sp_q == SP_TOP);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (wait_done) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign commit = (state_nxt == S_RESP) && !rst;

    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = req_cur.addr;
        ram_wdata = req_cur.data;
        if (commit) begin
            case (req_cur.op)
                OP_READ:  ram_re = 1'b1;
                OP_WRITE: ram_we = 1'b1;
                OP_PUSH: begin
                    ram_addr = sp_q;
                    ram_we   = !stack_full;
                end
                OP_POP: begin
                    ram_addr = sp_q + 1'b1;
                    ram_re   = !stack_empty;
                end
                default: ;
            endcase
        end
    end

    sp_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            req_q <= req_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            sp_q         <= SP_TOP;
            rsp_from_ram <= 1'b0;
            err_ov_q     <= 1'b0;
            err_un_q     <= 1'b0;
            err_il_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
            err_ov_q <= 1'b0;
            err_un_q <= 1'b0;
            err_il_q <= 1'b0;
            if (commit) begin
                // RAM output register only moves on a read, so the response
                // data holds naturally until the next commit.
                rsp_from_ram <= ram_re;
                err_ov_q     <= (req_cur.op == OP_PUSH) && stack_full;
                err_un_q     <= (req_cur.op == OP_POP) && stack_empty;
                err_il_q     <= (req_cur.op == OP_ILLEGAL);
                if (req_cur.op == OP_PUSH && !stack_full) begin
                    sp_q <= sp_q - 1'b1;
                end else if (req_cur.op == OP_POP && !stack_empty) begin
                    sp_q <= sp_q + 1'b1;
                end
            end
        end
    end

    assign bus.req_ready     = (state == S_IDLE);
    assign bus.rsp_valid     = (state == S_RESP);
    assign bus.rsp_data      = rsp_from_ram ? ram_rdata : '0;
    assign bus.sp            = sp_q;
    assign bus.err_overflow  = err_ov_q;
    assign bus.err_underflow = err_un_q;
    assign bus.err_illegal   = err_il_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: randomized and directed requests
// against a behavioural memory/stack model.
module tb_data_mem_responder;

    localparam int AW     = 11;
    localparam int DW     = 16;
    localparam int WS     = 2;
    localparam int SP_TOP = 2047;

    typedef struct {
        logic [15:0] data;
        bit          data_known;
        bit          ov;
        bit          un;
        bit          il;
        int          sp;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    data_mem_responder #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .WAIT_STATES (WS),
        .SP_TOP      (11'(SP_TOP))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb[$];
    logic [15:0] model_mem [2048];
    bit          known [2048];
    int          model_sp = SP_TOP;
    int          n_vec = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          started = 0;
    logic [15:0] last_data = '0;
    bit          last_known = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per response strobe.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (started) begin
                if (bus.rsp_valid) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got rsp_valid, expected none (cycle %0d)", cyc);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_cycle", cyc, e.cyc);
                        if (e.data_known) check("rsp_data", bus.rsp_data, e.data);
                        check("err_flags", {bus.err_overflow, bus.err_underflow, bus.err_illegal},
                              {e.ov, e.un, e.il});
                        check("sp", bus.sp, e.sp);
                        check("ready_in_rsp", bus.req_ready, 0);
                        last_data  = e.data;
                        last_known = e.data_known;
                    end
                end else begin
                    check("idle_err_flags", {bus.err_overflow, bus.err_underflow, bus.err_illegal}, 0);
                    if (last_known) check("rsp_data_hold", bus.rsp_data, last_data);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // All driving happens 1 time unit after a rising edge.
    task automatic issue(input bit r, input bit w, input bit pu, input bit po,
                         input logic [15:0] a, input logic [15:0] d, input bit abort);
        exp_t e;
        int   n;
        int   ai;
        int   guard;
        guard = 0;
        while (bus.req_ready !== 1'b1) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 50) begin
                n_vec++;
                n_fail++;
                $display("FAIL ready_timeout: req_ready stuck at %b, expected 1", bus.req_ready);
                return;
            end
        end
        bus.req_valid    = 1'b1;
        bus.memory_read  = r;
        bus.memory_write = w;
        bus.memory_push  = pu;
        bus.memory_pop   = po;
        bus.address      = a;
        bus.write_data   = d;
        @(posedge clk);
        #1;
        // Scramble inputs after the accept edge; the DUT must ignore them.
        bus.req_valid    = 1'b0;
        bus.memory_read  = 1'($urandom);
        bus.memory_write = 1'($urandom);
        bus.memory_push  = 1'($urandom);
        bus.memory_pop   = 1'($urandom);
        bus.address      = 16'($urandom);
        bus.write_data   = 16'($urandom);
        check("ready_after_accept", bus.req_ready, 0);
        if (abort) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst        = 1'b0;
            last_data  = '0;
            last_known = 1;
            check("abort_sp", bus.sp, SP_TOP);
            check("abort_ready", bus.req_ready, 1);
            model_sp = SP_TOP;
            return;
        end
        ai = int'(a[10:0]);
        n  = int'(r) + int'(w) + int'(pu) + int'(po);
        e.data = '0;
        e.data_known = 1;
        e.ov = 0;
        e.un = 0;
        e.il = 0;
        if (n != 1) begin
            e.il = 1;
        end else if (r) begin
            e.data = model_mem[ai];
            e.data_known = known[ai];
        end else if (w) begin
            model_mem[ai] = d;
            known[ai] = 1;
        end else if (pu) begin
            if (model_sp == 0) e.ov = 1;
            else begin
                model_mem[model_sp] = d;
                known[model_sp] = 1;
                model_sp--;
            end
        end else begin
            if (model_sp == SP_TOP) e.un = 1;
            else begin
                model_sp++;
                e.data = model_mem[model_sp];
                e.data_known = known[model_sp];
            end
        end
        e.sp  = model_sp;
        e.cyc = cyc + WS;
        sb.push_back(e);
    endtask

    initial begin
        logic [3:0]  v;
        logic [15:0] a;
        int          guard;
        bus.req_valid    = 1'b0;
        bus.memory_read  = 1'b0;
        bus.memory_write = 1'b0;
        bus.memory_push  = 1'b0;
        bus.memory_pop   = 1'b0;
        bus.address      = '0;
        bus.write_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_ready", bus.req_ready, 1);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_data", bus.rsp_data, 0);
        check("reset_sp", bus.sp, SP_TOP);
        check("reset_errs", {bus.err_overflow, bus.err_underflow, bus.err_illegal}, 0);
        last_known = 1;
        started    = 1;

        issue(0, 1, 0, 0, 16'd5, 16'h1234, 0);
        issue(1, 0, 0, 0, 16'd5, 16'h0000, 0);
        issue(0, 0, 0, 1, 16'd0, 16'h0000, 0);
        issue(0, 0, 1, 0, 16'd0, 16'hAAAA, 0);
        issue(0, 0, 1, 0, 16'd0, 16'hBBBB, 0);
        issue(0, 0, 0, 1, 16'd0, 16'h0000, 0);
        issue(0, 0, 0, 1, 16'd0, 16'h0000, 0);
        issue(1, 1, 0, 0, 16'd5, 16'hFFFF, 0);
        issue(0, 0, 0, 0, 16'd5, 16'hFFFF, 0);
        issue(1, 0, 0, 0, 16'hF805, 16'h0000, 0);
        issue(0, 1, 0, 0, 16'd7, 16'h0777, 0);
        issue(0, 1, 0, 0, 16'd7, 16'h5555, 1);
        issue(1, 0, 0, 0, 16'd7, 16'h0000, 0);

        repeat (400) begin
            a = {5'($urandom), ($urandom_range(0, 1) != 0) ? 11'($urandom_range(0, 15))
                                                           : 11'($urandom_range(2032, 2047))};
            case ($urandom_range(0, 9))
                0, 1, 2: issue(1, 0, 0, 0, a, 16'($urandom), 0);
                3, 4:    issue(0, 1, 0, 0, a, 16'($urandom), 0);
                5, 6:    issue(0, 0, 1, 0, a, 16'($urandom), 0);
                7, 8:    issue(0, 0, 0, 1, a, 16'($urandom), 0);
                default: begin
                    v = 4'($urandom);
                    while ($countones(v) == 1) v = 4'($urandom);
                    issue(v[3], v[2], v[1], v[0], a, 16'($urandom), 0);
                end
            endcase
        end

        // Fill the whole stack, overflow it, confirm address 0 intact, drain it.
        issue(0, 1, 0, 0, 16'd0, 16'hDEAD, 0);
        guard = 0;
        while (model_sp > 0 && guard < 3000) begin
            issue(0, 0, 1, 0, 16'd0, 16'($urandom), 0);
            guard++;
        end
        issue(0, 0, 1, 0, 16'd0, 16'h1111, 0);
        issue(1, 0, 0, 0, 16'd0, 16'h0000, 0);
        guard = 0;
        while (model_sp < SP_TOP && guard < 3000) begin
            issue(0, 0, 0, 1, 16'd0, 16'h0000, 0);
            guard++;
        end
        issue(0, 0, 0, 1, 16'd0, 16'h0000, 0);

        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
        end
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
